branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Execute-stage end of the branch-prediction loop. Compares the fetch-time prediction carried down the
//  pipe with the resolved branch outcome. Issues a registered redirect on mispredict, trains an 8-entry
//  2-bit direction table (PHT), and queues BTB fill/correct writes in a 4-deep FIFO drained by valid/ready.
//  Sits between EX and the fetch-side target buffer / PC mux.
// PARAMETERS
//  PC_W      32  PC / target width (equals `PC_WIDTH)
//  IDX_W     3   table index width; index = pc[IDX_W+1:2]
//  FIFO_D    4   update FIFO depth (power of 2)
//  MISS_W    16  mispredict counter width
// PORTS
//  clk_i           in   1      clock, rising edge
//  rst_n           in   1      synchronous reset, active-low
//  ex_valid        in   1      EX holds a valid instruction this cycle
//  ex_is_jmp       in   1      instruction is a branch/jump
//  ex_pc           in   PC_W   instruction PC
//  ex_pred_taken   in   1      fetch predicted taken (BTB hit & PHT taken)
//  ex_pred_target  in   PC_W   fetch predicted target (0 if not predicted)
//  ex_taken        in   1      resolved direction
//  ex_target       in   PC_W   resolved target
//  pht_rd_idx      in   IDX_W  fetch-side PHT lookup index
//  pht_rd_taken    out  1      PHT[pht_rd_idx][1], combinational
//  redirect_valid  out  1      1-cycle pulse: flush younger, refetch at redirect_pc
//  redirect_pc     out  PC_W   correct next PC
//  upd_valid       out  1      FIFO head holds a BTB write
//  upd_ready       in   1      BTB accepts head this cycle
//  upd_index       out  IDX_W  BTB index of head
//  upd_tag         out  PC_W   BTB tag (full PC) of head
//  upd_target      out  PC_W   BTB target of head
//  miss_cnt        out  MISS_W saturating mispredict count
//  drop_cnt        out  8      saturating count of updates dropped on FIFO full
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): redirect_valid=0, redirect_pc=0, FIFO empty (upd_valid=0, upd_* =0),
//   all PHT counters=2'b01, miss_cnt=0, drop_cnt=0. Mid-operation reset discards pending FIFO entries.
//  resolve = ex_valid & ex_is_jmp; idx = ex_pc[IDX_W+1:2].
//  mispredict (comb, cycle N):
//   - resolve & (ex_pred_taken != ex_taken)
//   - resolve & ex_taken & ex_pred_taken & (ex_pred_target != ex_target)
//   - ex_valid & ~ex_is_jmp & ex_pred_taken (BTB alias on non-branch)
//  Redirect: registered; at N+1 redirect_valid=1 for exactly one cycle. redirect_pc = ex_target if
//   resolve & ex_taken, else ex_pc+4 (PC_W wrap-around modulo 2^PC_W). No redirect when prediction right.
//  ex_valid is ignored in cycle N+1 (pipe flush); a valid there is not resolved or counted.
//  PHT: on resolve, PHT[idx] saturating +1 if ex_taken else -1 (3 stays 3, 0 stays 0); written at posedge
//   N. Read port reflects update from N+1 on; same-cycle read of idx returns old value.
//  BTB push: resolve & ex_taken & (~ex_pred_taken | ex_pred_target != ex_target) enqueues
//   {idx, ex_pc, ex_target}. Non-branch alias enqueues nothing (BTB entry ages out by overwrite).
//  FIFO: pop when upd_valid & upd_ready; upd_* stable while upd_valid & ~upd_ready. First-word
//   fall-through not required: pushed entry visible on upd_valid at earliest N+1.
//   Full & push & pop same cycle: both happen, no drop. Full & push & ~pop: entry dropped, drop_cnt+1
//   (saturate 255). Empty & pop impossible (upd_valid=0). Duplicate indices allowed; later entry wins.
//  miss_cnt +1 per mispredict, saturating at 2^MISS_W-1.
// STRUCTURE
//  define.v: PC_WIDTH, BTA_WIDTH, BTB index width, PHT reset value 2'b01, PC increment 4.
//  Sub-module btb_upd_fifo (params WIDTH, DEPTH; push/full, pop/empty, head data): circular buffer,
//   wrapping rd/wr pointers plus count. Top holds PHT, mispredict logic, redirect regs, counters.
// TESTING
//  Reset: rst_n=0 two cycles -> all outputs 0, pht_rd_taken=0 for idx 0..7, upd_valid=0.
//  Cold taken branch pc=0x100, pred_taken=0, taken=1, target=0x200 -> N+1 redirect 0x200 one cycle;
//   upd idx=0 tag=0x100 target=0x200; PHT[0] 1->2; miss_cnt=1.
//  Correct predict pc=0x104 pred 0x300, taken 0x300 -> no redirect, no push, PHT[1] trains; 3 more
//   taken -> saturates at 3; 4 not-taken -> saturates at 0.
//  Predicted taken, resolved not-taken pc=0xFFFFFFFC -> redirect_pc=0x0 (wrap), no push.
//  upd_ready=0, 5 cold taken branches -> entries 1-4 held in order, 5th dropped, drop_cnt=1;
//   repeat with upd_ready=1 on the full cycle -> no drop.
//  Reset asserted with 3 entries queued and redirect pending -> next cycle upd_valid=0, redirect_valid=0.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: shared widths, reset constants and PHT counter helper
package branch_resolve_unit_pkg;
  localparam int PC_WIDTH = 32;
  localparam int BTB_IDX_W = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int MISS_WIDTH = 16;
  localparam int PC_INC = 4;
  localparam logic [1:0] PHT_RST = 2'b01;
  function automatic logic [1:0] pht_next(input logic [1:0] c, input logic taken);
    return taken ? (c == 2'b11 ? c : c + 2'b01) : (c == 2'b00 ? c : c - 2'b01);
  endfunction
endpackage

// File: rtl/branch_resolve_unit_btb_upd_fifo.sv
// btb_upd_fifo: circular-buffer FIFO holding pending BTB writes, zero head when empty
module btb_upd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign full = r_cnt == (AW+1)'(DEPTH);
  assign empty = r_cnt == '0;
  assign w_pop = pop & ~empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push = push & (~full | w_pop);
  assign dout = empty ? '0 : r_mem[r_rd];
  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wr] <= din;
  always_ff @(posedge clk_i)
    if (!rst_n) begin
      r_rd <= '0;
      r_wr <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: checks fetch prediction against EX outcome, redirects, trains PHT, queues BTB fills
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int PC_W = PC_WIDTH,
  parameter int IDX_W = BTB_IDX_W,
  parameter int FIFO_D = FIFO_DEPTH,
  parameter int MISS_W = MISS_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_is_jmp,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_pred_taken,
  input  logic [PC_W-1:0]   ex_pred_target,
  input  logic              ex_taken,
  input  logic [PC_W-1:0]   ex_target,
  input  logic [IDX_W-1:0]  pht_rd_idx,
  output logic              pht_rd_taken,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              upd_valid,
  input  logic              upd_ready,
  output logic [IDX_W-1:0]  upd_index,
  output logic [PC_W-1:0]   upd_tag,
  output logic [PC_W-1:0]   upd_target,
  output logic [MISS_W-1:0] miss_cnt,
  output logic [7:0]        drop_cnt
);
  localparam int UW = IDX_W + 2*PC_W;
  logic [1:0] r_pht [2**IDX_W];
  logic r_redirect_valid;
  logic [PC_W-1:0] r_redirect_pc;
  logic [MISS_W-1:0] r_miss;
  logic [7:0] r_drop;
  logic w_v, w_resolve, w_mis, w_push, w_pop, w_full, w_empty;
  logic [IDX_W-1:0] w_idx;
  logic [UW-1:0] w_head;
  // the instruction right behind a redirect is being flushed, so it is ignored
  assign w_v = ex_valid & ~r_redirect_valid;
  assign w_resolve = w_v & ex_is_jmp;
  assign w_idx = ex_pc[IDX_W+1:2];
  assign w_mis = (w_resolve & (ex_pred_taken != ex_taken))
               | (w_resolve & ex_taken & ex_pred_taken & (ex_pred_target != ex_target))
               | (w_v & ~ex_is_jmp & ex_pred_taken);
  assign w_push = w_resolve & ex_taken & (~ex_pred_taken | (ex_pred_target != ex_target));
  assign w_pop = ~w_empty & upd_ready;
  assign pht_rd_taken = r_pht[pht_rd_idx][1];
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc = r_redirect_pc;
  assign upd_valid = ~w_empty;
  assign {upd_index, upd_tag, upd_target} = w_head;
  assign miss_cnt = r_miss;
  assign drop_cnt = r_drop;
  btb_upd_fifo #(.WIDTH(UW), .DEPTH(FIFO_D)) u_fifo (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .push  (w_push),
    .din   ({w_idx, ex_pc, ex_target}),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .dout  (w_head)
  );
  always_ff @(posedge clk_i)
    if (!rst_n) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc <= '0;
      r_miss <= '0;
      r_drop <= '0;
      for (int i = 0; i < 2**IDX_W; i++) r_pht[i] <= PHT_RST;
    end else begin
      r_redirect_valid <= w_mis;
      if (w_mis) r_redirect_pc <= (w_resolve & ex_taken) ? ex_target : ex_pc + PC_W'(PC_INC);
      if (w_resolve) r_pht[w_idx] <= pht_next(r_pht[w_idx], ex_taken);
      if (w_mis && r_miss != '1) r_miss <= r_miss + MISS_W'(1);
      if (w_push && w_full && !w_pop && r_drop != '1) r_drop <= r_drop + 8'd1;
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed scenarios plus randomized run against a queue/array reference model
module tb_branch_resolve_unit;
  logic clk_i = 0, rst_n = 0, ex_valid = 0, ex_is_jmp = 0, ex_pred_taken = 0, ex_taken = 0, upd_ready = 0;
  logic [31:0] ex_pc = 0, ex_pred_target = 0, ex_target = 0;
  logic [2:0] pht_rd_idx = 0;
  logic pht_rd_taken, redirect_valid, upd_valid;
  logic [31:0] redirect_pc, upd_tag, upd_target;
  logic [2:0] upd_index;
  logic [15:0] miss_cnt;
  logic [7:0] drop_cnt;
  int errs = 0, checks = 0;
  typedef struct {logic [2:0] idx; logic [31:0] tag; logic [31:0] tgt;} ent_t;
  ent_t m_q[$];
  int m_pht[8];
  bit m_rv;
  logic [31:0] m_rpc;
  int m_miss, m_drop;

  branch_resolve_unit dut (
    .clk_i(clk_i), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_jmp(ex_is_jmp), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .ex_taken(ex_taken),
    .ex_target(ex_target), .pht_rd_idx(pht_rd_idx), .pht_rd_taken(pht_rd_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .upd_valid(upd_valid),
    .upd_ready(upd_ready), .upd_index(upd_index), .upd_tag(upd_tag), .upd_target(upd_target),
    .miss_cnt(miss_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // drives one cycle and advances the reference model by the rules of the block
  task automatic cycle(input bit rst, input bit v, input bit j, input logic [31:0] pc, input bit pt,
                       input logic [31:0] ptgt, input bit t, input logic [31:0] tgt, input bit rdy);
    bit ev, res, mis, psh, pp;
    int p;
    rst_n = ~rst; ex_valid = v; ex_is_jmp = j; ex_pc = pc; ex_pred_taken = pt;
    ex_pred_target = ptgt; ex_taken = t; ex_target = tgt; upd_ready = rdy;
    ev = v && !m_rv;
    res = ev && j;
    mis = (res && pt != t) || (res && t && pt && ptgt != tgt) || (ev && !j && pt);
    psh = res && t && (!pt || ptgt != tgt);
    pp = m_q.size() > 0 && rdy;
    @(posedge clk_i);
    #1;
    if (rst) begin
      m_rv = 0; m_rpc = 0; m_miss = 0; m_drop = 0; m_q.delete();
      foreach (m_pht[i]) m_pht[i] = 1;
    end else begin
      m_rv = mis;
      if (mis) m_rpc = (res && t) ? tgt : pc + 32'd4;
      if (res) begin
        p = m_pht[pc[4:2]];
        m_pht[pc[4:2]] = t ? (p == 3 ? 3 : p + 1) : (p == 0 ? 0 : p - 1);
      end
      if (pp) void'(m_q.pop_front());
      if (psh) begin
        if (m_q.size() < 4) m_q.push_back('{pc[4:2], pc, tgt});
        else if (m_drop < 255) m_drop++;
      end
      if (mis && m_miss < 65535) m_miss++;
    end
  endtask

  task automatic idle(input bit rdy);
    cycle(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, rdy);
  endtask

  task automatic br(input logic [31:0] pc, input bit pt, input logic [31:0] ptgt, input bit t,
                    input logic [31:0] tgt, input bit rdy);
    cycle(0, 1, 1, pc, pt, ptgt, t, tgt, rdy);
  endtask

  task automatic test_reset;
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (redirect_valid !== 1'b0) begin errs++; $display("FAIL reset_rv got %0h exp 0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errs++; $display("FAIL reset_rpc got %0h exp 0", redirect_pc); end
    checks++; if (upd_valid !== 1'b0) begin errs++; $display("FAIL reset_upd_valid got %0h exp 0", upd_valid); end
    checks++; if ({upd_index, upd_tag, upd_target} !== 67'h0) begin errs++; $display("FAIL reset_upd_data got %0h/%0h/%0h exp 0", upd_index, upd_tag, upd_target); end
    checks++; if (miss_cnt !== 16'h0) begin errs++; $display("FAIL reset_miss got %0d exp 0", miss_cnt); end
    checks++; if (drop_cnt !== 8'h0) begin errs++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
    for (int i = 0; i < 8; i++) begin
      pht_rd_idx = 3'(i);
      #0.5;
      checks++; if (pht_rd_taken !== 1'b0) begin errs++; $display("FAIL reset_pht[%0d] got %0h exp 0", i, pht_rd_taken); end
    end
  endtask

  task automatic test_cold_taken;
    br(32'h100, 0, 32'h0, 1, 32'h200, 0);
    pht_rd_idx = 3'd0;
    #1;
    checks++; if (redirect_valid !== 1'b1) begin errs++; $display("FAIL cold_rv got %0h exp 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h200) begin errs++; $display("FAIL cold_rpc got %0h exp 200", redirect_pc); end
    checks++; if (upd_valid !== 1'b1 || upd_index !== 3'd0 || upd_tag !== 32'h100 || upd_target !== 32'h200)
      begin errs++; $display("FAIL cold_upd got v=%0h i=%0h t=%0h g=%0h exp v=1 i=0 t=100 g=200", upd_valid, upd_index, upd_tag, upd_target); end
    checks++; if (miss_cnt !== 16'd1) begin errs++; $display("FAIL cold_miss got %0d exp 1", miss_cnt); end
    checks++; if (pht_rd_taken !== 1'b1) begin errs++; $display("FAIL cold_pht0 got %0h exp 1", pht_rd_taken); end
    idle(1);
    checks++; if (redirect_valid !== 1'b0) begin errs++; $display("FAIL cold_rv_pulse got %0h exp 0", redirect_valid); end
    checks++; if (upd_valid !== 1'b0) begin errs++; $display("FAIL cold_popped got %0h exp 0", upd_valid); end
  endtask

  task automatic test_pht_train;
    bit exp_t [8] = '{1, 0, 0, 0, 0, 1, 1, 1};
    ex_valid = 1; ex_is_jmp = 1; ex_pc = 32'h104; ex_pred_taken = 1; ex_pred_target = 32'h300;
    ex_taken = 1; ex_target = 32'h300; pht_rd_idx = 3'd1;
    #1;
    checks++; if (pht_rd_taken !== 1'b0) begin errs++; $display("FAIL train_same_cycle got %0h exp 0", pht_rd_taken); end
    br(32'h104, 1, 32'h300, 1, 32'h300, 1);
    checks++; if (redirect_valid !== 1'b0 || upd_valid !== 1'b0) begin errs++; $display("FAIL train_no_redirect got rv=%0h uv=%0h exp 0/0", redirect_valid, upd_valid); end
    checks++; if (pht_rd_taken !== 1'b1) begin errs++; $display("FAIL train_first got %0h exp 1", pht_rd_taken); end
    for (int i = 0; i < 3; i++) br(32'h104, 1, 32'h300, 1, 32'h300, 1);
    // counter at 3: not-taken x4 then taken x3; expected read after each step
    for (int i = 0; i < 7; i++) begin
      if (i < 4) br(32'h104, 0, 32'h0, 0, 32'h108, 1);
      else br(32'h104, 1, 32'h300, 1, 32'h300, 1);
      checks++; if (pht_rd_taken !== exp_t[i]) begin errs++; $display("FAIL train_step%0d got %0h exp %0h", i, pht_rd_taken, exp_t[i]); end
    end
    checks++; if (miss_cnt !== 16'd1) begin errs++; $display("FAIL train_miss got %0d exp 1", miss_cnt); end
  endtask

  task automatic test_wrap;
    br(32'hFFFFFFFC, 1, 32'h10, 0, 32'h40, 1);
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin errs++; $display("FAIL wrap_rpc got rv=%0h pc=%0h exp 1/0", redirect_valid, redirect_pc); end
    checks++; if (upd_valid !== 1'b0) begin errs++; $display("FAIL wrap_no_push got %0h exp 0", upd_valid); end
    checks++; if (miss_cnt !== 16'd2) begin errs++; $display("FAIL wrap_miss got %0d exp 2", miss_cnt); end
    idle(1);
  endtask

  task automatic test_fifo_full;
    for (int i = 0; i < 5; i++) begin
      br(32'h400 + 32'(4*i), 0, 32'h0, 1, 32'hA00 + 32'(4*i), 0);
      checks++; if (drop_cnt !== 8'(i == 4)) begin errs++; $display("FAIL full_drop%0d got %0d exp %0d", i, drop_cnt, i == 4); end
      checks++; if (upd_tag !== 32'h400) begin errs++; $display("FAIL full_hold%0d got %0h exp 400", i, upd_tag); end
      idle(0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (upd_valid !== 1'b1 || upd_index !== 3'(i) || upd_tag !== 32'h400 + 32'(4*i) || upd_target !== 32'hA00 + 32'(4*i))
        begin errs++; $display("FAIL full_order%0d got v=%0h i=%0h t=%0h g=%0h", i, upd_valid, upd_index, upd_tag, upd_target); end
      idle(1);
    end
    checks++; if (upd_valid !== 1'b0) begin errs++; $display("FAIL full_drained got %0h exp 0", upd_valid); end
    for (int i = 0; i < 4; i++) begin
      br(32'h500 + 32'(4*i), 0, 32'h0, 1, 32'hB00 + 32'(4*i), 0);
      idle(0);
    end
    br(32'h510, 0, 32'h0, 1, 32'hB10, 1);
    checks++; if (drop_cnt !== 8'd1) begin errs++; $display("FAIL full_pop_push_drop got %0d exp 1", drop_cnt); end
    idle(0);
    for (int i = 1; i < 5; i++) begin
      checks++; if (upd_valid !== 1'b1 || upd_tag !== 32'h500 + 32'(4*i) || upd_target !== 32'hB00 + 32'(4*i))
        begin errs++; $display("FAIL full_order2_%0d got v=%0h t=%0h g=%0h", i, upd_valid, upd_tag, upd_target); end
      idle(1);
    end
    checks++; if (miss_cnt !== 16'd12) begin errs++; $display("FAIL full_miss got %0d exp 12", miss_cnt); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      br(32'h600 + 32'(4*i), 0, 32'h0, 1, 32'hC00, 0);
      idle(0);
    end
    checks++; if (upd_valid !== 1'b1) begin errs++; $display("FAIL mid_queued got %0h exp 1", upd_valid); end
    cycle(1, 1, 1, 32'h700, 1, 32'h20, 0, 32'h40, 0);
    checks++; if (redirect_valid !== 1'b0 || upd_valid !== 1'b0) begin errs++; $display("FAIL mid_reset got rv=%0h uv=%0h exp 0/0", redirect_valid, upd_valid); end
    checks++; if (miss_cnt !== 16'd0) begin errs++; $display("FAIL mid_miss got %0d exp 0", miss_cnt); end
    idle(1);
  endtask

  task automatic test_random;
    logic [31:0] pcs, pt_t, t_t;
    int idx;
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      idx = $urandom_range(7);
      pht_rd_idx = 3'(idx);
      #1;
      checks++; if (pht_rd_taken !== (m_pht[idx] >= 2)) begin errs++; $display("FAIL rnd_pht n=%0d got %0h exp %0h", n, pht_rd_taken, m_pht[idx] >= 2); end
      pcs = ($urandom_range(9) == 0) ? 32'hFFFFFFFC : 32'h1000 + 32'(4*$urandom_range(15));
      pt_t = 32'h2000 + 32'(4*$urandom_range(1));
      t_t = 32'h2000 + 32'(4*$urandom_range(1));
      cycle($urandom_range(99) == 0, $urandom_range(9) < 7, $urandom_range(9) < 7, pcs,
            1'($urandom_range(1)), pt_t, 1'($urandom_range(1)), t_t, 1'($urandom_range(1)));
      checks++; if (redirect_valid !== m_rv) begin errs++; $display("FAIL rnd_rv n=%0d got %0h exp %0h", n, redirect_valid, m_rv); end
      if (m_rv) begin
        checks++; if (redirect_pc !== m_rpc) begin errs++; $display("FAIL rnd_rpc n=%0d got %0h exp %0h", n, redirect_pc, m_rpc); end
      end
      checks++; if (upd_valid !== (m_q.size() > 0)) begin errs++; $display("FAIL rnd_uv n=%0d got %0h exp %0h", n, upd_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        checks++; if (upd_index !== m_q[0].idx || upd_tag !== m_q[0].tag || upd_target !== m_q[0].tgt)
          begin errs++; $display("FAIL rnd_head n=%0d got %0h/%0h/%0h exp %0h/%0h/%0h", n, upd_index, upd_tag, upd_target, m_q[0].idx, m_q[0].tag, m_q[0].tgt); end
      end
      checks++; if (miss_cnt !== 16'(m_miss)) begin errs++; $display("FAIL rnd_miss n=%0d got %0d exp %0d", n, miss_cnt, m_miss); end
      checks++; if (drop_cnt !== 8'(m_drop)) begin errs++; $display("FAIL rnd_drop n=%0d got %0d exp %0d", n, drop_cnt, m_drop); end
    end
  endtask

  initial begin
    #2;
    test_reset;
    test_cold_taken;
    test_pht_train;
    test_wrap;
    test_fifo_full;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
